usb_rx_sequencer: RTL and testbench

USB_RX_SEQUENCER -- requirements
Module: usb_rx_sequencer

---
 rtl/usb_rx_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_usb_rx_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_sequencer.sv
// usb_rx_sequencer
// Tracks one USB packet at a time on the receive side: flushes the RX FIFO
// when a packet starts, decodes its PID, counts the bytes written into the
// FIFO, catches overflow and receive errors, and then hands the bytes to the
// host, counting them back down as the host reads them.
//
// Handshake note: w_enable, pid_set, host_read and host_clear are single-cycle
// pulses sampled on the rising clock edge. There is no back-pressure, so every
// pulse is consumed in the cycle it appears or ignored by the current state.
//
// state_dbg exposes the FSM state for checkers:
//   0 = IDLE, 1 = FLUSH, 2 = ACTIVE, 3 = DONE, 4 = ERROR.
module usb_rx_sequencer #(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rcving,
    input  logic       r_error,
    input  logic       w_enable,
    input  logic       pid_set,
    input  logic [3:0] rx_pid,
    input  logic       host_read,
    input  logic       host_clear,
    output logic       flush,
    output logic       rx_transfer_active,
    output logic       rx_data_ready,
    output logic       rx_error,
    output logic       overflow,
    output logic [2:0] rx_packet,
    output logic [6:0] byte_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        ACTIVE = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    // Largest legal byte count for one packet, in the counter's own width.
    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    // Decoded packet types.
    localparam logic [2:0] PKT_NONE  = 3'd0;
    localparam logic [2:0] PKT_OUT   = 3'd1;
    localparam logic [2:0] PKT_IN    = 3'd2;
    localparam logic [2:0] PKT_DATA0 = 3'd3;
    localparam logic [2:0] PKT_DATA1 = 3'd4;
    localparam logic [2:0] PKT_ACK   = 3'd5;
    localparam logic [2:0] PKT_NAK   = 3'd6;
    localparam logic [2:0] PKT_OTHER = 3'd7;

    state_t     state;
    state_t     state_n;
    logic       rcving_q;
    logic       rcving_seen_low;
    logic       rcving_rise;
    logic       rcving_fall;
    logic [6:0] count_n;
    logic [2:0] packet_n;
    logic       overflow_n;

    // Maps the low nibble of the PID onto the packet-type code.
    function automatic logic [2:0] pid_decode(input logic [3:0] pid);
        logic [2:0] kind;
        case (pid)
            4'b0001: kind = PKT_OUT;
            4'b1001: kind = PKT_IN;
            4'b0011: kind = PKT_DATA0;
            4'b1011: kind = PKT_DATA1;
            4'b0010: kind = PKT_ACK;
            4'b1010: kind = PKT_NAK;
            default: kind = PKT_OTHER;
        endcase
        return kind;
    endfunction

    // Only DATA0/DATA1 packets carry bytes meant for the host.
    function automatic logic is_data(input logic [2:0] kind);
        return (kind == PKT_DATA0) || (kind == PKT_DATA1);
    endfunction

    // A rise only counts once rcving has been seen low after reset, so a
    // receiver that is still busy when reset releases does not start a
    // spurious packet (and no flush is issued on release).
    assign rcving_rise = rcving && !rcving_q && rcving_seen_low;
    assign rcving_fall = !rcving && rcving_q;

    assign state_dbg = state;

    // Next-state, counter, packet-type and overflow decisions.
    always_comb begin
        state_n    = state;
        count_n    = byte_count;
        packet_n   = rx_packet;
        overflow_n = overflow;

        case (state)
            IDLE: begin
                if (rcving_rise) begin
                    state_n = FLUSH;
                end
            end

            FLUSH: begin
                // Flush is always exactly one cycle long.
                if (r_error) begin
                    state_n = ERROR;
                end else begin
                    state_n = ACTIVE;
                end
            end

            ACTIVE: begin
                if (pid_set) begin
                    packet_n = pid_decode(rx_pid);
                end
                if (r_error) begin
                    // An error wins over a byte write or end of packet.
                    state_n = ERROR;
                end else begin
                    if (w_enable) begin
                        if (byte_count < MAX_CNT) begin
                            count_n = byte_count + 7'd1;
                        end else begin
                            overflow_n = 1'b1;
                            state_n    = ERROR;
                        end
                    end
                    // A byte written in the last cycle still counts.
                    if (rcving_fall && (state_n == ACTIVE)) begin
                        state_n = DONE;
                    end
                end
            end

            DONE: begin
                if (rcving_rise) begin
                    // A new packet discards whatever the host has not read.
                    state_n = FLUSH;
                end else if (host_clear) begin
                    state_n    = IDLE;
                    overflow_n = 1'b0;
                end else if (host_read && (byte_count != 7'd0)) begin
                    count_n = byte_count - 7'd1;
                    if ((byte_count == 7'd1) && is_data(rx_packet)) begin
                        state_n = IDLE;
                    end
                end
            end

            ERROR: begin
                if (rcving_rise) begin
                    state_n = FLUSH;
                end else if (host_clear) begin
                    state_n    = IDLE;
                    overflow_n = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Every new packet starts from a clean slate.
        if (state_n == FLUSH) begin
            count_n    = 7'd0;
            packet_n   = PKT_NONE;
            overflow_n = 1'b0;
        end
    end

    // State, counters and registered outputs; outputs are derived from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            rcving_q           <= 1'b0;
            rcving_seen_low    <= 1'b0;
            byte_count         <= 7'd0;
            rx_packet          <= PKT_NONE;
            overflow           <= 1'b0;
            flush              <= 1'b0;
            rx_transfer_active <= 1'b0;
            rx_data_ready      <= 1'b0;
            rx_error           <= 1'b0;
        end else begin
            state              <= state_n;
            rcving_q           <= rcving;
            if (!rcving) begin
                rcving_seen_low <= 1'b1;
            end
            byte_count         <= count_n;
            rx_packet          <= packet_n;
            overflow           <= overflow_n;
            flush              <= (state_n == FLUSH);
            rx_transfer_active <= (state_n == FLUSH) || (state_n == ACTIVE);
            rx_data_ready      <= (state_n == DONE) && is_data(packet_n) &&
                                  (count_n != 7'd0);
            rx_error           <= (state_n == ERROR);
        end
    end

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// tb_usb_rx_sequencer
// Drives two sequencers (MAX_BYTES = 64 and MAX_BYTES = 4) from the same
// inputs. A packet-level reference model predicts every output each cycle;
// directed scenarios also check the headline values of each scenario.
module tb_usb_rx_sequencer;

    // Model modes, matching the documented state_dbg codes.
    localparam int M_IDLE   = 0;
    localparam int M_FLUSH  = 1;
    localparam int M_ACTIVE = 2;
    localparam int M_DONE   = 3;
    localparam int M_ERROR  = 4;

    typedef struct {
        int mode;
        int cnt;
        int pkt;
        bit ovf;
        bit prev_rcv;
        bit seen_low;
        int max_bytes;
    } model_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic n_rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rcving, r_error, w_enable, pid_set, host_read, host_clear;
    logic [3:0] rx_pid;

    logic       a_flush, a_active, a_ready, a_err, a_ovf;
    logic [2:0] a_pkt, a_state;
    logic [6:0] a_cnt;
    logic       b_flush, b_active, b_ready, b_err, b_ovf;
    logic [2:0] b_pkt, b_state;
    logic [6:0] b_cnt;

    usb_rx_sequencer #(.MAX_BYTES(64)) dut_a (
        .clk(clk), .n_rst(n_rst), .rcving(rcving), .r_error(r_error),
        .w_enable(w_enable), .pid_set(pid_set), .rx_pid(rx_pid),
        .host_read(host_read), .host_clear(host_clear),
        .flush(a_flush), .rx_transfer_active(a_active), .rx_data_ready(a_ready),
        .rx_error(a_err), .overflow(a_ovf), .rx_packet(a_pkt),
        .byte_count(a_cnt), .state_dbg(a_state)
    );

    usb_rx_sequencer #(.MAX_BYTES(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .rcving(rcving), .r_error(r_error),
        .w_enable(w_enable), .pid_set(pid_set), .rx_pid(rx_pid),
        .host_read(host_read), .host_clear(host_clear),
        .flush(b_flush), .rx_transfer_active(b_active), .rx_data_ready(b_ready),
        .rx_error(b_err), .overflow(b_ovf), .rx_packet(b_pkt),
        .byte_count(b_cnt), .state_dbg(b_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    model_t m_a, m_b;

    // ---------------- reference model ----------------
    function automatic int pid_type(input logic [3:0] pid);
        case (pid)
            4'b0001: return 1;
            4'b1001: return 2;
            4'b0011: return 3;
            4'b1011: return 4;
            4'b0010: return 5;
            4'b1010: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic model_t model_reset(input int max_bytes);
        model_t m;
        m.mode = M_IDLE; m.cnt = 0; m.pkt = 0; m.ovf = 0;
        m.prev_rcv = 0; m.seen_low = 0; m.max_bytes = max_bytes;
        return m;
    endfunction

    function automatic model_t start_packet(input model_t m);
        m.mode = M_FLUSH; m.cnt = 0; m.pkt = 0; m.ovf = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m);
        bit rise, fall, is_data;
        rise    = rcving && !m.prev_rcv && m.seen_low;
        fall    = !rcving && m.prev_rcv;
        is_data = (m.pkt == 3) || (m.pkt == 4);
        if (m.mode == M_IDLE) begin
            if (rise) m = start_packet(m);
        end else if (m.mode == M_FLUSH) begin
            m.mode = r_error ? M_ERROR : M_ACTIVE;
        end else if (m.mode == M_ACTIVE) begin
            if (pid_set) m.pkt = pid_type(rx_pid);
            if (r_error) begin
                m.mode = M_ERROR;
            end else if (w_enable && m.cnt == m.max_bytes) begin
                m.ovf  = 1;
                m.mode = M_ERROR;
            end else begin
                if (w_enable) m.cnt++;
                if (fall) m.mode = M_DONE;
            end
        end else if (m.mode == M_DONE) begin
            if (rise) begin
                m = start_packet(m);
            end else if (host_clear) begin
                m.mode = M_IDLE; m.ovf = 0;
            end else if (host_read && m.cnt > 0) begin
                m.cnt--;
                if (m.cnt == 0 && is_data) m.mode = M_IDLE;
            end
        end else begin
            if (rise) begin
                m = start_packet(m);
            end else if (host_clear) begin
                m.mode = M_IDLE; m.ovf = 0;
            end
        end
        m.prev_rcv = rcving;
        if (!rcving) m.seen_low = 1;
        return m;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string name, input model_t m,
                             input logic fl, input logic act, input logic rdy,
                             input logic er, input logic ov, input logic [2:0] pk,
                             input logic [6:0] cn, input logic [2:0] st);
        chk({name, "_state"},  st,  m.mode);
        chk({name, "_flush"},  fl,  m.mode == M_FLUSH);
        chk({name, "_active"}, act, m.mode == M_FLUSH || m.mode == M_ACTIVE);
        chk({name, "_ready"},  rdy, m.mode == M_DONE && (m.pkt == 3 || m.pkt == 4) && m.cnt != 0);
        chk({name, "_rxerr"},  er,  m.mode == M_ERROR);
        chk({name, "_ovf"},    ov,  m.ovf);
        chk({name, "_pkt"},    pk,  m.pkt);
        chk({name, "_cnt"},    cn,  m.cnt);
    endtask

    task automatic check_all();
        check_one("a", m_a, a_flush, a_active, a_ready, a_err, a_ovf, a_pkt, a_cnt, a_state);
        check_one("b", m_b, b_flush, b_active, b_ready, b_err, b_ovf, b_pkt, b_cnt, b_state);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: models advance with the inputs seen at the edge, outputs are
    // checked 1 time unit later, then single-cycle pulses are dropped.
    task automatic tick();
        @(posedge clk);
        m_a = model_step(m_a);
        m_b = model_step(m_b);
        #1;
        check_all();
        w_enable = 0; pid_set = 0; host_read = 0; host_clear = 0;
    endtask

    task automatic pulse_writes(input int n);
        for (int i = 0; i < n; i++) begin
            w_enable = 1;
            tick();
        end
    endtask

    task automatic send_pid(input logic [3:0] pid);
        rx_pid  = pid;
        pid_set = 1;
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        n_rst = 0; rcving = 0; r_error = 0; w_enable = 0; pid_set = 0;
        rx_pid = 4'd0; host_read = 0; host_clear = 0;
        m_a = model_reset(64);
        m_b = model_reset(4);
        #3;
        check_all();
        #9 n_rst = 1;
        tick();
        tick();

        // DATA0 with 5 bytes: a keeps them, b (limit 4) overflows.
        rcving = 1;
        tick();
        chk("d0_flush_hi", a_flush, 1);
        tick();
        chk("d0_flush_lo", a_flush, 0);
        send_pid(4'b0011);
        pulse_writes(5);
        rcving = 0;
        tick();
        chk("d0_pkt", a_pkt, 3);
        chk("d0_cnt", a_cnt, 5);
        chk("d0_ready", a_ready, 1);
        chk("ovf_cnt", b_cnt, 4);
        chk("ovf_flag", b_ovf, 1);
        chk("ovf_rxerr", b_err, 1);
        for (int i = 0; i < 5; i++) begin
            host_read = 1;
            tick();
        end
        chk("d0_drain_cnt", a_cnt, 0);
        chk("d0_drain_state", a_state, M_IDLE);
        chk("d0_drain_ready", a_ready, 0);
        host_clear = 1;
        tick();
        chk("ovf_clr_state", b_state, M_IDLE);
        chk("ovf_clr_flag", b_ovf, 0);

        // ACK: no data, held in DONE until host_clear.
        rcving = 1;
        tick();
        tick();
        send_pid(4'b0010);
        rcving = 0;
        tick();
        chk("ack_pkt", a_pkt, 5);
        chk("ack_ready", a_ready, 0);
        host_read = 1;
        tick();
        tick();
        tick();
        chk("ack_hold", a_state, M_DONE);
        host_clear = 1;
        tick();
        chk("ack_clr", a_state, M_IDLE);

        // r_error after 2 bytes, then the next packet flushes it away.
        rcving = 1;
        tick();
        tick();
        send_pid(4'b0011);
        pulse_writes(2);
        r_error = 1;
        w_enable = 1;
        tick();
        chk("rerr_state", a_state, M_ERROR);
        chk("rerr_rxerr", a_err, 1);
        chk("rerr_cnt", a_cnt, 2);
        r_error = 0;
        rcving = 0;
        tick();
        rcving = 1;
        tick();
        chk("rerr_flush", a_flush, 1);
        chk("rerr_clr_err", a_err, 0);
        chk("rerr_clr_cnt", a_cnt, 0);

        // DATA1 with 3 bytes, preempted by a new packet while unread.
        tick();
        send_pid(4'b1011);
        pulse_writes(3);
        rcving = 0;
        tick();
        chk("pre_cnt", a_cnt, 3);
        chk("pre_ready", a_ready, 1);
        rcving = 1;
        host_clear = 1;
        tick();
        chk("pre_state", a_state, M_FLUSH);
        chk("pre_cnt0", a_cnt, 0);
        chk("pre_ready0", a_ready, 0);
        tick();

        // Reset mid-packet with 7 bytes counted.
        pulse_writes(7);
        chk("rst_pre_cnt", a_cnt, 7);
        #3 n_rst = 0;
        m_a = model_reset(64);
        m_b = model_reset(4);
        #1;
        check_all();
        chk("rst_cnt", a_cnt, 0);
        chk("rst_active", a_active, 0);
        #2 n_rst = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_noflush", a_flush, 0);
        end
        rcving = 0;
        tick();
        rcving = 1;
        tick();
        chk("rst_newpkt_flush", a_flush, 1);
        tick();
        rcving = 0;
        tick();
        host_clear = 1;
        tick();

        // Random traffic; the model checks every output each cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) rcving = ~rcving;
            r_error    = ($urandom_range(0, 99) == 0);
            w_enable   = rcving && ($urandom_range(0, 2) != 0);
            pid_set    = ($urandom_range(0, 11) == 0);
            rx_pid     = 4'($urandom_range(0, 15));
            host_read  = ($urandom_range(0, 2) == 0);
            host_clear = ($urandom_range(0, 39) == 0);
            tick();
        end
        // Long packets so the 64-byte limit is reached too.
        for (int p = 0; p < 3; p++) begin
            rcving = 0;
            tick();
            rcving = 1;
            tick();
            tick();
            send_pid(4'b1011);
            pulse_writes(63 + p);
            rcving = 0;
            tick();
            for (int i = 0; i < 70; i++) begin
                host_read = ($urandom_range(0, 1) == 1);
                tick();
            end
            host_clear = 1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
